div_unit: RTL and testbench

Iterative radix-2 integer divider for the RV64 M extension. It sits in the EX stage beside the combinational ALU and takes over DIV/DIVU/REM/REMU, so the single-cycle division path leaves the critical path. It accepts operands from the ID/EX register over a valid/ready handshake. It returns a 64-bit result to the EX/MEM writeback mux over a second valid/ready handshake, and asserts `busy` so the hazard unit can stall the front end.

---
 rtl/div_unit.sv | 209 ++++++++++++++++++++
 tb/tb_div_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring integer divider for RV64 M
// (DIV/DIVU/REM/REMU).
// Normal ops take XLEN iterations plus one fix-up cycle. Divide-by-zero
// and signed overflow skip straight to DONE at the accept edge.
// Optional macro DIV_WORD_OPS_EN enables the 32-bit W variants, which are
// selected with in_word and take 32 iterations.
//
// Ports:
//   clk, rst        - clock (rising edge) and synchronous active-high reset
//   flush           - abandons any in-flight operation, returns to IDLE
//   in_valid/ready  - operand handshake; in_ready high only in IDLE
//   in_op           - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   in_word         - W variant select (ignored unless DIV_WORD_OPS_EN)
//   in_a, in_b      - dividend, divisor
//   out_valid/ready - result handshake; out_result held while stalled
//   out_result      - quotient or remainder
//   busy            - high whenever not IDLE (hazard-unit stall)
module div_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam int unsigned CW = 6;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
`ifdef DIV_WORD_OPS_EN
  localparam logic [XLEN-1:0] MIN_NEG_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};
`endif

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            op_rem_q, op_rem_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            word_q, word_d;
  logic [XLEN-1:0] result_d;
  logic            in_ready_d, out_valid_d, busy_d;

  // Operand conditioning: extension, signs, magnitudes, special cases
  logic            is_signed, is_rem, word;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_neg;
  logic            sa, sb, div_zero, ovf;
  logic [XLEN-1:0] special_res;

  assign is_signed = ~in_op[0];
  assign is_rem    = in_op[1];

`ifdef DIV_WORD_OPS_EN
  assign word    = in_word;
  assign a_ext   = !word ? in_a :
                   is_signed ? {{(XLEN-32){in_a[31]}}, in_a[31:0]}
                             : {{(XLEN-32){1'b0}}, in_a[31:0]};
  assign b_ext   = !word ? in_b :
                   is_signed ? {{(XLEN-32){in_b[31]}}, in_b[31:0]}
                             : {{(XLEN-32){1'b0}}, in_b[31:0]};
  assign min_neg = word ? MIN_NEG_W : MIN_NEG;
`else
  logic word_unused;
  assign word_unused = in_word;
  assign word    = 1'b0;
  assign a_ext   = in_a;
  assign b_ext   = in_b;
  assign min_neg = MIN_NEG;
`endif

  assign sa       = is_signed & a_ext[XLEN-1];
  assign sb       = is_signed & b_ext[XLEN-1];
  assign a_mag    = sa ? XLEN'(XLEN'(0) - a_ext) : a_ext;
  assign b_mag    = sb ? XLEN'(XLEN'(0) - b_ext) : b_ext;
  assign div_zero = (b_ext == '0);
  assign ovf      = is_signed & (a_ext == min_neg) & (b_ext == '1);

  // W results are sign-extended from bit 31, unsigned ops included
  function automatic logic [XLEN-1:0] word_fix(input logic [XLEN-1:0] v,
                                               input logic w);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  assign special_res = word_fix(div_zero ? (is_rem ? a_ext : '1)
                                         : (is_rem ? '0 : a_ext), word);

  // One restoring step; rem < dvs keeps the XLEN+1-bit difference exact
  logic [XLEN:0]   rem_sh, diff;
  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};

  // Sign fix-up and op select
  logic [XLEN-1:0] q_fin, r_fin, fix_res;
  assign q_fin   = q_neg_q ? XLEN'(XLEN'(0) - quo_q) : quo_q;
  assign r_fin   = r_neg_q ? XLEN'(XLEN'(0) - rem_q) : rem_q;
  assign fix_res = word_fix(op_rem_q ? r_fin : q_fin, word_q);

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    op_rem_d = op_rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    word_d   = word_q;
    result_d = out_result;

    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          op_rem_d = is_rem;
          q_neg_d  = sa ^ sb;
          r_neg_d  = sa;
          word_d   = word;
          rem_d    = '0;
          dvs_d    = b_mag;
          if (div_zero || ovf) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
`ifdef DIV_WORD_OPS_EN
            // W ops: park the 32-bit dividend at the top so 32 shifts consume it
            quo_d = word ? (a_mag << 32) : a_mag;
            cnt_d = word ? CW'(31) : CW'(XLEN-1);
`else
            quo_d = a_mag;
            cnt_d = CW'(XLEN-1);
`endif
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!diff[XLEN]) begin
          rem_d = diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      FIX: begin
        result_d = fix_res;
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) state_d = IDLE;

    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      op_rem_q   <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      word_q     <= 1'b0;
      out_result <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      cnt_q      <= cnt_d;
      op_rem_q   <= op_rem_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      word_q     <= word_d;
      out_result <= result_d;
      in_ready   <= in_ready_d;
      out_valid  <= out_valid_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit (XLEN = 64).
// Result offsets are counted in rising edges from the accept edge:
// 65 for a normal 64-bit op, 0 for a special case.
module tb_div_unit;

  localparam int unsigned XLEN = 64;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01,
                         OP_REM = 2'b10, OP_REMU = 2'b11;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, in_word;
  logic [1:0]      in_op;
  logic [XLEN-1:0] in_a, in_b, out_result;
  logic            out_valid, out_ready, busy;

  int vectors = 0;
  int miscompares = 0;

  div_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_word(in_word), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Present one op at the next falling edge; returns after the accept edge (+1)
  task automatic issue(input logic [1:0] op, input logic w,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    @(negedge clk);
    in_op = op; in_word = w; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Bounded wait for out_valid, then check offset and result
  task automatic wait_result(input string tag, input logic [XLEN-1:0] exp,
                             input int exp_off);
    int off = 0;
    while (!out_valid && off < 200) begin
      @(posedge clk); #1;
      off++;
    end
    check({tag, "_lat"}, XLEN'(off), XLEN'(exp_off));
    check({tag, "_res"}, out_result, exp);
  endtask

  // Full op with out_ready high; confirms the handshake clears out_valid
  task automatic run(input string tag, input logic [1:0] op, input logic w,
                     input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                     input logic [XLEN-1:0] exp, input int exp_off);
    issue(op, w, a, b);
    wait_result(tag, exp, exp_off);
    @(posedge clk); #1;
    check({tag, "_drain"}, XLEN'(out_valid), XLEN'(0));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_word = 1'b0;
    in_op = OP_DIV; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready",  XLEN'(in_ready),  XLEN'(1));
    check("rst_out_valid", XLEN'(out_valid), XLEN'(0));
    check("rst_busy",      XLEN'(busy),      XLEN'(0));
    check("rst_result",    out_result,       '0);

    // Basic signed/unsigned quotients and remainders
    issue(OP_DIV, 1'b0, 64'd100, 64'd7);
    check("calc_busy",     XLEN'(busy),     XLEN'(1));
    check("calc_in_ready", XLEN'(in_ready), XLEN'(0));
    wait_result("div_100_7", 64'd14, 65);
    @(posedge clk); #1;
    run("rem_100_7",  OP_REM,  1'b0, 64'd100, 64'd7, 64'd2, 65);
    run("div_m7_2",   OP_DIV,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run("rem_m7_2",   OP_REM,  1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run("remu_m7_2",  OP_REMU, 1'b0, -64'sd7, 64'd2, 64'd1, 65);
    run("div_7_m2",   OP_DIV,  1'b0, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run("rem_7_m2",   OP_REM,  1'b0, 64'd7, -64'sd2, 64'd1, 65);
    run("divu_big",   OP_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10,
        64'h0FFF_FFFF_FFFF_FFFF, 65);
    run("remu_big",   OP_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 65);

    // Special cases complete at the accept edge
    run("divu_5_0",   OP_DIVU, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run("remu_5_0",   OP_REMU, 1'b0, 64'd5, 64'd0, 64'd5, 0);
    run("rem_m5_0",   OP_REM,  1'b0, -64'sd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 0);
    run("div_ovf",    OP_DIV,  1'b0, 64'h8000_0000_0000_0000, '1,
        64'h8000_0000_0000_0000, 0);
    run("rem_ovf",    OP_REM,  1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 0);
    run("divu_nonovf", OP_DIVU, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 65);

    // Backpressure: result held, no accept, taken on first out_ready
    out_ready = 1'b0;
    issue(OP_DIV, 1'b0, 64'd100, 64'd7);
    wait_result("bp", 64'd14, 65);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_res",   out_result,        64'd14);
      check("bp_hold_valid", XLEN'(out_valid),  XLEN'(1));
      check("bp_hold_ready", XLEN'(in_ready),   XLEN'(0));
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_taken_valid", XLEN'(out_valid), XLEN'(0));
    check("bp_taken_ready", XLEN'(in_ready),  XLEN'(1));

    // Flush mid-CALC wins over a simultaneous in_valid
    issue(OP_DIV, 1'b0, 64'd1000, 64'd3);
    repeat (29) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_op = OP_DIVU; in_a = 64'd50; in_b = 64'd0;
    @(posedge clk); #1;
    check("fl_valid", XLEN'(out_valid), XLEN'(0));
    check("fl_ready", XLEN'(in_ready),  XLEN'(1));
    check("fl_busy",  XLEN'(busy),      XLEN'(0));
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b1; in_op = OP_DIVU; in_a = 64'd50; in_b = 64'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("fl_new_busy", XLEN'(busy), XLEN'(1));
    wait_result("fl_new", 64'd8, 65);
    @(posedge clk); #1;

    // Reset mid-operation
    issue(OP_DIV, 1'b0, 64'd9, 64'd2);
    repeat (10) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_ready",  XLEN'(in_ready),  XLEN'(1));
    check("mrst_busy",   XLEN'(busy),      XLEN'(0));
    check("mrst_valid",  XLEN'(out_valid), XLEN'(0));
    check("mrst_result", out_result,       '0);

`ifdef DIV_WORD_OPS_EN
    run("divw_ovf",  OP_DIV,  1'b1, 64'h0000_0000_8000_0000, '1,
        64'hFFFF_FFFF_8000_0000, 0);
    run("divuw_3",   OP_DIVU, 1'b1, 64'h1_0000_0010, 64'd3, 64'd5, 33);
    run("remw_m7_2", OP_REM,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
        64'hFFFF_FFFF_FFFF_FFFF, 33);
`else
    // in_word is ignored: full 64-bit divide
    run("word_ign",  OP_DIVU, 1'b1, 64'h1_0000_0010, 64'd3, 64'h5555_555A, 65);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
